// File: rtl/rf_wb_scheduler.sv
// Register-file write-back scheduler: buffers M/E write requests in a small FIFO,
// drains one write per cycle, and tracks outstanding writes per register for RAW stalls.
module rf_wb_pend_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec_a,
  input  logic             i_dec_b,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_up, w_dn, w_diff;
  logic [CNT_W-1:0] w_nxt;

  assign w_up   = {1'b0, r_cnt} + (CNT_W+1)'(i_inc);
  assign w_dn   = (CNT_W+1)'(i_dec_a) + (CNT_W+1)'(i_dec_b);
  assign w_diff = w_up - w_dn;

  // Net change of the cycle, clamped so the counter neither underflows nor wraps.
  always_comb begin
    w_nxt = '0;
    if (w_up > w_dn) w_nxt = w_diff[CNT_W] ? '1 : w_diff[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_nxt;
  end

  assign o_cnt = r_cnt;
endmodule

module rf_wb_scheduler #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rsv_valid,
  input  logic [2:0]               rsv_reg,
  output logic                     rsv_ready,
  input  logic                     m_valid,
  input  logic [2:0]               m_reg,
  input  logic [DATA_W-1:0]        m_data,
  output logic                     m_ready,
  input  logic                     e_valid,
  input  logic [2:0]               e_reg,
  input  logic [DATA_W-1:0]        e_data,
  output logic                     e_ready,
  input  logic [2:0]               q_srcA,
  input  logic [2:0]               q_srcB,
  output logic                     stall,
  output logic                     rf_we_,
  output logic [2:0]               rf_dst,
  output logic [DATA_W-1:0]        rf_data,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [2:0]        dst;
    logic [DATA_W-1:0] data;
  } wb_ent_t;

  wb_ent_t          r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_rf_we_;
  logic [2:0]       r_rf_dst;
  logic [DATA_W-1:0] r_rf_data;

  logic [CW-1:0]    w_free;
  logic             w_m_live;
  logic             w_m_acc, w_e_acc, w_m_enq, w_e_enq, w_coll, w_deq;
  logic [AW-1:0]    w_e_idx;
  logic [CNT_W-1:0] w_pend [8];

  // Space is judged on start-of-cycle occupancy only; a same-cycle pop never helps.
  assign w_free   = CW'(DEPTH) - r_count;
  assign w_m_live = m_valid && (m_reg != 3'd0);
  assign m_ready  = (m_reg == 3'd0) || (w_free >= CW'(1));
  assign e_ready  = (e_reg == 3'd0) ||
                    (w_m_live ? (w_free >= CW'(2)) : (w_free >= CW'(1)));

  assign w_m_acc = m_valid && m_ready;
  assign w_e_acc = e_valid && e_ready;
  assign w_m_enq = w_m_acc && (m_reg != 3'd0);
  assign w_coll  = w_m_enq && w_e_acc && (e_reg == m_reg);
  assign w_e_enq = w_e_acc && (e_reg != 3'd0) && !w_coll;
  assign w_deq   = (r_count != '0);
  assign w_e_idx = r_wptr + AW'(w_m_enq);

  always_ff @(posedge clk) begin
    if (w_m_enq) r_mem[r_wptr]  <= '{dst: m_reg, data: m_data};
    if (w_e_enq) r_mem[w_e_idx] <= '{dst: e_reg, data: e_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_rf_we_  <= 1'b1;
      r_rf_dst  <= '0;
      r_rf_data <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_m_enq) + AW'(w_e_enq);
      r_count <= r_count + CW'(w_m_enq) + CW'(w_e_enq) - CW'(w_deq);
      if (w_deq) begin
        r_rptr    <= r_rptr + AW'(1);
        r_rf_we_  <= 1'b0;
        r_rf_dst  <= r_mem[r_rptr].dst;
        r_rf_data <= r_mem[r_rptr].data;
      end else begin
        r_rf_we_  <= 1'b1;
      end
    end
  end

  // Counters retire on the edge where the RF actually captures the strobe, so a
  // stalled reader sees the new value in the very cycle its stall drops.
  assign w_pend[0] = '0;
  for (genvar g = 1; g < 8; g++) begin : g_pend
    rf_wb_pend_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (rsv_valid && rsv_ready && (rsv_reg == 3'(g))),
      .i_dec_a (!r_rf_we_ && (r_rf_dst == 3'(g))),
      .i_dec_b (w_coll && (m_reg == 3'(g))),
      .o_cnt   (w_pend[g])
    );
  end

  assign rsv_ready = (w_pend[rsv_reg] != '1);
  assign stall     = ((q_srcA != 3'd0) && (w_pend[q_srcA] != '0)) ||
                     ((q_srcB != 3'd0) && (w_pend[q_srcB] != '0));

  assign rf_we_     = r_rf_we_;
  assign rf_dst     = r_rf_dst;
  assign rf_data    = r_rf_data;
  assign fifo_count = r_count;
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed table-driven bench for rf_wb_scheduler: one row per clock cycle.
module tb_rf_wb_scheduler;
  logic        clk, rst;
  logic        rsv_valid, rsv_ready;
  logic [2:0]  rsv_reg;
  logic        m_valid, m_ready, e_valid, e_ready;
  logic [2:0]  m_reg, e_reg, q_srcA, q_srcB, rf_dst;
  logic [31:0] m_data, e_data, rf_data;
  logic        stall, rf_we_;
  logic [2:0]  fifo_count;

  int errors = 0;
  int checks = 0;

  rf_wb_scheduler #(.DATA_W(32), .DEPTH(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .rsv_valid(rsv_valid), .rsv_reg(rsv_reg), .rsv_ready(rsv_ready),
    .m_valid(m_valid), .m_reg(m_reg), .m_data(m_data), .m_ready(m_ready),
    .e_valid(e_valid), .e_reg(e_reg), .e_data(e_data), .e_ready(e_ready),
    .q_srcA(q_srcA), .q_srcB(q_srcB), .stall(stall),
    .rf_we_(rf_we_), .rf_dst(rf_dst), .rf_data(rf_data), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rv;
    logic [2:0]  rr;
    logic        mv;
    logic [2:0]  mr;
    logic [31:0] md;
    logic        ev;
    logic [2:0]  er;
    logic [31:0] ed;
    logic [2:0]  qa, qb;
    logic        x_mrdy, x_erdy, x_rrdy, x_stall, x_we;
    logic [2:0]  x_dst;
    logic [31:0] x_data;
    logic [2:0]  x_cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t hand[$];

  function automatic vec_t V(int r, int rv, int rr, int mv, int mr, int md, int ev, int er, int ed,
                             int qa, int qb, int mrdy, int erdy, int rrdy, int st, int we,
                             int dst, int data, int cnt);
    vec_t v;
    v.rst = 1'(r);   v.rv = 1'(rv); v.rr = 3'(rr);
    v.mv = 1'(mv);   v.mr = 3'(mr); v.md = 32'(md);
    v.ev = 1'(ev);   v.er = 3'(er); v.ed = 32'(ed);
    v.qa = 3'(qa);   v.qb = 3'(qb);
    v.x_mrdy = 1'(mrdy); v.x_erdy = 1'(erdy); v.x_rrdy = 1'(rrdy);
    v.x_stall = 1'(st);  v.x_we = 1'(we);
    v.x_dst = 3'(dst); v.x_data = 32'(data); v.x_cnt = 3'(cnt);
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row %0d %s: got %h expected %h", row, nm, act, exp);
    end
  endtask

  // Drive inputs for one cycle, then check outputs before the closing edge.
  task automatic apply(input vec_t v, input int row);
    @(negedge clk);
    rst = v.rst; rsv_valid = v.rv; rsv_reg = v.rr;
    m_valid = v.mv; m_reg = v.mr; m_data = v.md;
    e_valid = v.ev; e_reg = v.er; e_data = v.ed;
    q_srcA = v.qa; q_srcB = v.qb;
    #1;
    chk("m_ready",    row, 32'(m_ready),    32'(v.x_mrdy));
    chk("e_ready",    row, 32'(e_ready),    32'(v.x_erdy));
    chk("rsv_ready",  row, 32'(rsv_ready),  32'(v.x_rrdy));
    chk("stall",      row, 32'(stall),      32'(v.x_stall));
    chk("rf_we_",     row, 32'(rf_we_),     32'(v.x_we));
    chk("fifo_count", row, 32'(fifo_count), 32'(v.x_cnt));
    if (!v.x_we) begin
      chk("rf_dst",  row, 32'(rf_dst), 32'(v.x_dst));
      chk("rf_data", row, rf_data,     v.x_data);
    end
  endtask

  initial begin
    rst = 1'b1; rsv_valid = 0; rsv_reg = 0; m_valid = 0; m_reg = 0; m_data = 0;
    e_valid = 0; e_reg = 0; e_data = 0; q_srcA = 0; q_srcB = 0;
    repeat (2) @(posedge clk);

    //                rst rv rr  mv mr md       ev er ed       qa qb  mr er rr st we dst data     cnt
    // single write r3
    tbl.push_back(V(0, 1, 3,  0, 0, 0,       0, 0, 0,       3, 0,  1, 1, 1, 0, 1, 0, 0,       0));
    tbl.push_back(V(0, 0, 0,  1, 3, 'h1234,  0, 0, 0,       3, 0,  1, 1, 1, 1, 1, 0, 0,       0));
    tbl.push_back(V(0, 0, 0,  0, 0, 0,       0, 0, 0,       3, 0,  1, 1, 1, 1, 1, 0, 0,       1));
    tbl.push_back(V(0, 0, 0,  0, 0, 0,       0, 0, 0,       3, 0,  1, 1, 1, 1, 0, 3, 'h1234,  0));
    tbl.push_back(V(0, 0, 0,  0, 0, 0,       0, 0, 0,       3, 0,  1, 1, 1, 0, 1, 0, 0,       0));
    // dual request, M before E; unreserved writes leave counters at 0
    tbl.push_back(V(0, 0, 0,  1, 2, 'hAA,    1, 5, 'hBB,    2, 5,  1, 1, 1, 0, 1, 0, 0,       0));
    tbl.push_back(V(0, 0, 0,  0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 1, 0, 1, 0, 0,       2));
    tbl.push_back(V(0, 0, 0,  0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 1, 0, 0, 2, 'hAA,    1));
    tbl.push_back(V(0, 0, 0,  0, 0, 0,       0, 0, 0,       2, 5,  1, 1, 1, 0, 0, 5, 'hBB,    0));
    // collision on r4
    tbl.push_back(V(0, 1, 4,  0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 1, 0, 1, 0, 0,       0));
    tbl.push_back(V(0, 1, 4,  0, 0, 0,       0, 0, 0,       4, 0,  1, 1, 1, 1, 1, 0, 0,       0));
    tbl.push_back(V(0, 0, 0,  1, 4, 'h11,    1, 4, 'h22,    4, 0,  1, 1, 1, 1, 1, 0, 0,       0));
    tbl.push_back(V(0, 0, 0,  0, 0, 0,       0, 0, 0,       4, 0,  1, 1, 1, 1, 1, 0, 0,       1));
    tbl.push_back(V(0, 0, 0,  0, 0, 0,       0, 0, 0,       4, 0,  1, 1, 1, 1, 0, 4, 'h11,    0));
    tbl.push_back(V(0, 0, 0,  0, 0, 0,       0, 0, 0,       4, 0,  1, 1, 1, 0, 1, 0, 0,       0));
    // backpressure: occupancy climbs to 3 (free=1), order preserved
    tbl.push_back(V(0, 0, 0,  1, 1, 1,       1, 2, 2,       0, 0,  1, 1, 1, 0, 1, 0, 0,       0));
    tbl.push_back(V(0, 0, 0,  1, 3, 3,       1, 5, 5,       0, 0,  1, 1, 1, 0, 1, 0, 0,       2));
    tbl.push_back(V(0, 0, 0,  1, 6, 6,       1, 7, 7,       0, 0,  1, 0, 1, 0, 0, 1, 1,       3));
    tbl.push_back(V(0, 0, 0,  1, 0, 'hFF,    1, 7, 7,       0, 0,  1, 1, 1, 0, 0, 2, 2,       3));
    tbl.push_back(V(0, 0, 0,  0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 1, 0, 0, 3, 3,       3));
    tbl.push_back(V(0, 0, 0,  0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 1, 0, 0, 5, 5,       2));
    tbl.push_back(V(0, 0, 0,  0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 1, 0, 0, 6, 6,       1));
    tbl.push_back(V(0, 0, 0,  0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 1, 0, 0, 7, 7,       0));
    // R0 write discarded; r1 saturation
    tbl.push_back(V(0, 1, 1,  1, 0, 'hFF,    0, 0, 0,       0, 0,  1, 1, 1, 0, 1, 0, 0,       0));
    tbl.push_back(V(0, 1, 1,  0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 1, 0, 1, 0, 0,       0));
    tbl.push_back(V(0, 1, 1,  0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 1, 0, 1, 0, 0,       0));
    tbl.push_back(V(0, 1, 1,  0, 0, 0,       0, 0, 0,       1, 0,  1, 1, 0, 1, 1, 0, 0,       0));
    tbl.push_back(V(0, 1, 0,  1, 1, 'h5A,    0, 0, 0,       1, 0,  1, 1, 1, 1, 1, 0, 0,       0));
    tbl.push_back(V(0, 1, 1,  0, 0, 0,       0, 0, 0,       1, 0,  1, 1, 0, 1, 1, 0, 0,       1));
    tbl.push_back(V(0, 1, 1,  0, 0, 0,       0, 0, 0,       1, 0,  1, 1, 0, 1, 0, 1, 'h5A,    0));
    tbl.push_back(V(0, 0, 1,  0, 0, 0,       0, 0, 0,       1, 0,  1, 1, 1, 1, 1, 0, 0,       0));
    // reset for two cycles during traffic
    tbl.push_back(V(0, 1, 3,  1, 6, 'h66,    1, 3, 'h33,    3, 5,  1, 1, 1, 0, 1, 0, 0,       0));
    tbl.push_back(V(1, 0, 0,  1, 2, 'h22,    0, 0, 0,       3, 5,  1, 1, 1, 1, 1, 0, 0,       2));
    tbl.push_back(V(1, 0, 0,  1, 2, 'h22,    0, 0, 0,       3, 5,  1, 1, 1, 0, 1, 0, 0,       0));
    tbl.push_back(V(0, 0, 0,  0, 0, 0,       0, 0, 0,       3, 5,  1, 1, 1, 0, 1, 0, 0,       0));
    tbl.push_back(V(0, 0, 1,  0, 0, 0,       0, 0, 0,       1, 0,  1, 1, 1, 0, 1, 0, 0,       0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Reservation landing on the same edge as a capture of that register nets to zero.
    hand.push_back(V(0, 1, 3,  0, 0, 0,      0, 0, 0,       3, 0,  1, 1, 1, 0, 1, 0, 0,       0));
    hand.push_back(V(0, 0, 0,  1, 3, 'h77,   0, 0, 0,       3, 0,  1, 1, 1, 1, 1, 0, 0,       0));
    hand.push_back(V(0, 0, 0,  0, 0, 0,      0, 0, 0,       3, 0,  1, 1, 1, 1, 1, 0, 0,       1));
    hand.push_back(V(0, 1, 3,  0, 0, 0,      0, 0, 0,       3, 0,  1, 1, 1, 1, 0, 3, 'h77,    0));
    hand.push_back(V(0, 0, 0,  1, 3, 'h78,   0, 0, 0,       3, 0,  1, 1, 1, 1, 1, 0, 0,       0));
    hand.push_back(V(0, 0, 0,  0, 0, 0,      0, 0, 0,       0, 3,  1, 1, 1, 1, 1, 0, 0,       1));
    hand.push_back(V(0, 0, 0,  0, 0, 0,      0, 0, 0,       3, 0,  1, 1, 1, 1, 0, 3, 'h78,    0));
    hand.push_back(V(0, 0, 0,  0, 0, 0,      0, 0, 0,       3, 3,  1, 1, 1, 0, 1, 0, 0,       0));
    for (int i = 0; i < hand.size(); i++) apply(hand[i], 100 + i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
